// File: rtl/inst_fetch_responder_if.sv
// -----------------------------------------------------------------------------
// inst_fetch_responder_if
// Bundles the fetch request/response handshake and the store preload port of
// the instruction fetch responder.
//   fetch_e_   : request valid, active low           (fetch side -> responder)
//   fetch_pc   : requested PC                        (fetch side -> responder)
//   fetch_busy : request this cycle not accepted     (responder -> fetch side)
//   flush_     : active low, kills outstanding work  (fetch side -> responder)
//   inst_e_    : response valid, active low          (responder -> fetch side)
//   inst_pc    : PC of the returned instruction      (responder -> fetch side)
//   inst       : returned instruction                (responder -> fetch side)
//   inst_err   : misaligned / out-of-range PC        (responder -> fetch side)
//   inst_stall : consumer refuses response this cycle(fetch side -> responder)
//   ld_e_/ld_addr/ld_data : store write port         (fetch side -> responder)
// Modports: master = fetch side / loader, slave = responder.
// -----------------------------------------------------------------------------
interface inst_fetch_responder_if #(
  parameter int ADDR      = 32,
  parameter int INST      = 32,
  parameter int MEM_DEPTH = 1024
) ();
  localparam int AW = $clog2(MEM_DEPTH);

  logic            fetch_e_;
  logic [ADDR-1:0] fetch_pc;
  logic            fetch_busy;
  logic            flush_;
  logic            inst_e_;
  logic [ADDR-1:0] inst_pc;
  logic [INST-1:0] inst;
  logic            inst_err;
  logic            inst_stall;
  logic            ld_e_;
  logic [AW-1:0]   ld_addr;
  logic [INST-1:0] ld_data;

  modport master (
    output fetch_e_, fetch_pc, flush_, inst_stall, ld_e_, ld_addr, ld_data,
    input  fetch_busy, inst_e_, inst_pc, inst, inst_err
  );

  modport slave (
    input  fetch_e_, fetch_pc, flush_, inst_stall, ld_e_, ld_addr, ld_data,
    output fetch_busy, inst_e_, inst_pc, inst, inst_err
  );
endinterface

// File: rtl/inst_fetch_responder.sv
// -----------------------------------------------------------------------------
// inst_fetch_responder
// Memory-side responder for instruction fetch. Accepted PCs are looked up in a
// word-addressed instruction store and returned LATENCY cycles later through a
// credit-limited response queue, so a stalled consumer never loses data.
// A flush discards everything outstanding but accepts the request presented in
// the same cycle (the redirect target).
// Ports:
//   clk    : clock
//   reset_ : asynchronous active-low reset (store contents are not reset)
//   bus    : inst_fetch_responder_if.slave (request, response, flush, preload)
// -----------------------------------------------------------------------------
module inst_fetch_responder #(
  parameter int              ADDR      = 32,
  parameter int              INST      = 32,
  parameter int              MEM_DEPTH = 1024,
  parameter int              LATENCY   = 2,
  parameter int              Q_DEPTH   = 4,
  parameter logic [INST-1:0] NOP       = INST'(32'h0000_0013)
) (
  input  logic                    clk,
  input  logic                    reset_,
  inst_fetch_responder_if.slave   bus
);

  localparam int AW = $clog2(MEM_DEPTH);
  localparam int QW = (Q_DEPTH > 1) ? $clog2(Q_DEPTH) : 1;
  localparam int CW = $clog2(Q_DEPTH + 1);
  // Register stages ahead of the queue; the queue write is the last stage.
  localparam int NS = (LATENCY > 1) ? LATENCY - 1 : 1;

  logic [INST-1:0] mem_q [MEM_DEPTH];

  logic [AW-1:0]   word_idx;
  logic            lookup_err;
  logic            accept;
  logic            pop;

  logic [CW-1:0]   cnt_q, cnt_d;

  logic            push_vld;
  logic [ADDR-1:0] push_pc;
  logic [INST-1:0] push_data;
  logic            push_err;

  logic [ADDR-1:0]    q_pc_q   [Q_DEPTH];
  logic [INST-1:0]    q_inst_q [Q_DEPTH];
  logic [Q_DEPTH-1:0] q_err_q;
  logic [QW-1:0]      rd_ptr_q, rd_ptr_d;
  logic [QW-1:0]      wr_ptr_q, wr_ptr_d;
  logic [QW-1:0]      wr_idx;
  logic [CW-1:0]      q_cnt_q, q_cnt_d;
  logic               q_vld;

  // ---------------------------------------------------------------------------
  // Request decode and credit check
  // ---------------------------------------------------------------------------
  assign word_idx   = bus.fetch_pc[2 +: AW];
  assign lookup_err = (bus.fetch_pc[1:0] != 2'b00) ||
                      ({2'b00, bus.fetch_pc[ADDR-1:2]} >= ADDR'(MEM_DEPTH));

  // Busy comes only from the registered credit count, never from fetch_e_.
  assign bus.fetch_busy = (cnt_q == CW'(Q_DEPTH));
  assign accept         = !bus.fetch_e_ && !bus.fetch_busy;

  assign q_vld = (q_cnt_q != '0);
  assign pop   = q_vld && !bus.inst_stall;

  // ---------------------------------------------------------------------------
  // Instruction store write port; reads below see the pre-write contents
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!bus.ld_e_) begin
      mem_q[bus.ld_addr] <= bus.ld_data;
    end
  end

  // ---------------------------------------------------------------------------
  // Lookup pipeline feeding the queue push
  // ---------------------------------------------------------------------------
  generate
    if (LATENCY == 1) begin : g_direct
      // Single-cycle latency: the queue write itself is the only register.
      assign push_vld  = accept;
      assign push_pc   = bus.fetch_pc;
      assign push_err  = lookup_err;
      assign push_data = mem_q[word_idx];
    end else begin : g_pipe
      logic [NS-1:0]   st_vld_q;
      logic [NS-1:0]   st_err_q;
      logic [ADDR-1:0] st_pc_q   [NS];
      logic [INST-1:0] st_inst_q [NS];

      // Stage 0 data is the registered store read; later stages just shift.
      always_ff @(posedge clk) begin
        st_inst_q[0] <= mem_q[word_idx];
        for (int i = 1; i < NS; i++) begin
          st_inst_q[i] <= st_inst_q[i-1];
        end
      end

      // A flush kills what is already in flight, but stage 0 still loads the
      // request accepted in the flush cycle.
      always_ff @(posedge clk or negedge reset_) begin
        if (!reset_) begin
          st_vld_q <= '0;
          st_err_q <= '0;
          for (int i = 0; i < NS; i++) begin
            st_pc_q[i] <= '0;
          end
        end else begin
          st_vld_q[0] <= accept;
          st_err_q[0] <= lookup_err;
          st_pc_q[0]  <= bus.fetch_pc;
          for (int i = 1; i < NS; i++) begin
            st_vld_q[i] <= st_vld_q[i-1] && bus.flush_;
            st_err_q[i] <= st_err_q[i-1];
            st_pc_q[i]  <= st_pc_q[i-1];
          end
        end
      end

      assign push_vld  = st_vld_q[NS-1] && bus.flush_;
      assign push_pc   = st_pc_q[NS-1];
      assign push_err  = st_err_q[NS-1];
      assign push_data = st_inst_q[NS-1];
    end
  endgenerate

  // ---------------------------------------------------------------------------
  // Response queue and credit counter
  // ---------------------------------------------------------------------------
  function automatic logic [QW-1:0] ptr_inc(input logic [QW-1:0] p);
    return (p == QW'(Q_DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  always_comb begin
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    wr_idx   = wr_ptr_q;
    q_cnt_d  = q_cnt_q;
    cnt_d    = cnt_q;
    if (!bus.flush_) begin
      // Queue restarts empty; only a same-cycle push (LATENCY == 1) survives.
      rd_ptr_d = '0;
      wr_idx   = '0;
      wr_ptr_d = push_vld ? ptr_inc('0) : '0;
      q_cnt_d  = CW'(push_vld);
      cnt_d    = CW'(accept);
    end else begin
      if (pop)      rd_ptr_d = ptr_inc(rd_ptr_q);
      if (push_vld) wr_ptr_d = ptr_inc(wr_ptr_q);
      q_cnt_d = q_cnt_q + CW'(push_vld) - CW'(pop);
      cnt_d   = cnt_q + CW'(accept) - CW'(pop);
    end
  end

  always_ff @(posedge clk) begin
    if (push_vld) begin
      q_pc_q[wr_idx]   <= push_pc;
      q_inst_q[wr_idx] <= push_err ? NOP : push_data;
      q_err_q[wr_idx]  <= push_err;
    end
  end

  always_ff @(posedge clk or negedge reset_) begin
    if (!reset_) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      q_cnt_q  <= '0;
      cnt_q    <= '0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      q_cnt_q  <= q_cnt_d;
      cnt_q    <= cnt_d;
    end
  end

  // Head of queue drives the response; data fields read as zero when empty.
  assign bus.inst_e_  = !q_vld;
  assign bus.inst_pc  = q_vld ? q_pc_q[rd_ptr_q]   : '0;
  assign bus.inst     = q_vld ? q_inst_q[rd_ptr_q] : '0;
  assign bus.inst_err = q_vld ? q_err_q[rd_ptr_q]  : 1'b0;

endmodule
